// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue/decode/execute/writeback sequencer for the 16-bit ALU and register file.
// Optional build macro SEQ_RETIRE_CNT_EN adds a wrapping retired-instruction counter.
module alu_op_sequencer #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter logic [3:0]  OP_CMP      = 4'hE,
  parameter logic [3:0]  OP_NOP      = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  rf_raddr1,
  output logic [3:0]  rf_raddr2,
  input  logic [15:0] rf_rdata1,
  input  logic [15:0] rf_rdata2,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [3:0]  alu_ctrl,
  input  logic [15:0] alu_out,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [3:0]  flags,
  output logic        done,
  output logic [15:0] retired
);

  // state  | meaning
  // IDLE   | ready for a new instruction
  // DECODE | present source addresses, capture operands
  // EXEC   | hold ALU inputs for ALU_LATENCY cycles, sample result/flags on last
  // WB     | retire pulse, register writeback unless CMP/NOP
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op;

  assign op    = ir_q[15:12];
  assign flags = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from state_q only, so an async reset drops rf_we/done at once.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    rf_raddr1   = '0;
    rf_raddr2   = '0;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_ctrl    = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rf_raddr1 = ir_q[7:4];
        rf_raddr2 = ir_q[3:0];
        opa_d     = rf_rdata1;
        opb_d     = rf_rdata2;
        if (op == OP_NOP) begin
          state_d = S_WB;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_in1  = opa_q;
        alu_in2  = opb_q;
        alu_ctrl = op;
        if (cnt_q == 4'd0) begin
          res_d   = alu_out;
          flags_d = {alu_n, alu_z, alu_c, alu_v};
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB: begin
        done = 1'b1;
        if ((op != OP_CMP) && (op != OP_NOP)) begin
          rf_we    = 1'b1;
          rf_waddr = ir_q[11:8];
          rf_wdata = res_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retired_q, retired_d;

  assign retired_d = retired_q + {15'd0, done};
  assign retired   = retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end
`else
  assign retired = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: instance 0 runs ALU_LATENCY=1, instance 1 runs ALU_LATENCY=3,
// each with its own register-file and ALU (add/sub, borrow as C) model.
module tb_alu_op_sequencer;

  logic        clk;
  logic        load;
  logic        rst_n       [2];
  logic        instr_valid [2];
  logic        instr_ready [2];
  logic [15:0] instr       [2];
  logic [3:0]  rf_raddr1   [2];
  logic [3:0]  rf_raddr2   [2];
  logic [15:0] rf_rdata1   [2];
  logic [15:0] rf_rdata2   [2];
  logic [15:0] alu_in1     [2];
  logic [15:0] alu_in2     [2];
  logic [3:0]  alu_ctrl    [2];
  logic [15:0] alu_out     [2];
  logic        alu_n       [2];
  logic        alu_z       [2];
  logic        alu_c       [2];
  logic        alu_v       [2];
  logic        rf_we       [2];
  logic [3:0]  rf_waddr    [2];
  logic [15:0] rf_wdata    [2];
  logic [3:0]  flags       [2];
  logic        done        [2];
  logic [15:0] retired     [2];

  int n_chk  = 0;
  int n_fail = 0;
  int exp_ret [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] rf [16];
    logic [16:0] sum;

    alu_op_sequencer #(.ALU_LATENCY((g == 0) ? 1 : 3)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .instr_valid (instr_valid[g]),
      .instr_ready (instr_ready[g]),
      .instr       (instr[g]),
      .rf_raddr1   (rf_raddr1[g]),
      .rf_raddr2   (rf_raddr2[g]),
      .rf_rdata1   (rf_rdata1[g]),
      .rf_rdata2   (rf_rdata2[g]),
      .alu_in1     (alu_in1[g]),
      .alu_in2     (alu_in2[g]),
      .alu_ctrl    (alu_ctrl[g]),
      .alu_out     (alu_out[g]),
      .alu_n       (alu_n[g]),
      .alu_z       (alu_z[g]),
      .alu_c       (alu_c[g]),
      .alu_v       (alu_v[g]),
      .rf_we       (rf_we[g]),
      .rf_waddr    (rf_waddr[g]),
      .rf_wdata    (rf_wdata[g]),
      .flags       (flags[g]),
      .done        (done[g]),
      .retired     (retired[g])
    );

    assign rf_rdata1[g] = rf[rf_raddr1[g]];
    assign rf_rdata2[g] = rf[rf_raddr2[g]];

    always @(posedge clk) begin
      if (load) begin
        for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
        rf[1] <= 16'h00AA;
        rf[2] <= 16'h0011;
        rf[5] <= 16'h0005;
        rf[6] <= 16'h0005;
      end else if (rf_we[g]) begin
        rf[rf_waddr[g]] <= rf_wdata[g];
      end
    end

    always_comb begin
      sum      = 17'd0;
      alu_v[g] = 1'b0;
      case (alu_ctrl[g])
        4'h0: begin
          sum      = {1'b0, alu_in1[g]} + {1'b0, alu_in2[g]};
          alu_v[g] = (alu_in1[g][15] == alu_in2[g][15]) && (sum[15] != alu_in1[g][15]);
        end
        4'h1, 4'hE: begin
          sum      = {1'b0, alu_in1[g]} - {1'b0, alu_in2[g]};
          alu_v[g] = (alu_in1[g][15] != alu_in2[g][15]) && (sum[15] != alu_in1[g][15]);
        end
        default: sum = 17'd0;
      endcase
      alu_out[g] = sum[15:0];
      alu_n[g]   = sum[15];
      alu_z[g]   = (sum[15:0] == 16'h0000);
      alu_c[g]   = sum[16];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] ret_exp(input int d);
`ifdef SEQ_RETIRE_CNT_EN
    return 16'(exp_ret[d]);
`else
    return 16'h0000;
`endif
  endfunction

  // Called at a negedge with the instance idle; returns at the negedge after WB (IDLE again).
  task automatic run_instr(input int d, input logic [15:0] ins, input logic [15:0] ea,
                           input logic [15:0] eb, input logic ewe, input logic [15:0] ewd,
                           input logic [3:0] efl);
    int lat;
    lat = (d == 0) ? 1 : 3;
    check_eq($sformatf("d%0d_%h_ready_idle", d, ins), instr_ready[d], 1);
    instr[d]       = ins;
    instr_valid[d] = 1'b1;
    @(negedge clk);
    instr_valid[d] = 1'b0;
    instr[d]       = 16'hDEAD;
    check_eq($sformatf("d%0d_%h_dec_ready", d, ins), instr_ready[d], 0);
    check_eq($sformatf("d%0d_%h_dec_ra1", d, ins), rf_raddr1[d], ins[7:4]);
    check_eq($sformatf("d%0d_%h_dec_ra2", d, ins), rf_raddr2[d], ins[3:0]);
    check_eq($sformatf("d%0d_%h_dec_ctrl", d, ins), alu_ctrl[d], 0);
    check_eq($sformatf("d%0d_%h_dec_done", d, ins), done[d], 0);
    if (ins[15:12] != 4'hF) begin
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        check_eq($sformatf("d%0d_%h_ex%0d_in1", d, ins, k), alu_in1[d], ea);
        check_eq($sformatf("d%0d_%h_ex%0d_in2", d, ins, k), alu_in2[d], eb);
        check_eq($sformatf("d%0d_%h_ex%0d_ctrl", d, ins, k), alu_ctrl[d], ins[15:12]);
        check_eq($sformatf("d%0d_%h_ex%0d_done", d, ins, k), done[d], 0);
        check_eq($sformatf("d%0d_%h_ex%0d_we", d, ins, k), rf_we[d], 0);
      end
    end
    @(negedge clk);
    exp_ret[d]++;
    check_eq($sformatf("d%0d_%h_wb_done", d, ins), done[d], 1);
    check_eq($sformatf("d%0d_%h_wb_we", d, ins), rf_we[d], ewe);
    if (ewe) begin
      check_eq($sformatf("d%0d_%h_wb_waddr", d, ins), rf_waddr[d], ins[11:8]);
      check_eq($sformatf("d%0d_%h_wb_wdata", d, ins), rf_wdata[d], ewd);
    end
    check_eq($sformatf("d%0d_%h_wb_flags", d, ins), flags[d], efl);
    check_eq($sformatf("d%0d_%h_wb_ctrl", d, ins), alu_ctrl[d], 0);
    check_eq($sformatf("d%0d_%h_wb_ready", d, ins), instr_ready[d], 0);
    @(negedge clk);
    check_eq($sformatf("d%0d_%h_post_ready", d, ins), instr_ready[d], 1);
    check_eq($sformatf("d%0d_%h_post_done", d, ins), done[d], 0);
    check_eq($sformatf("d%0d_%h_post_we", d, ins), rf_we[d], 0);
    check_eq($sformatf("d%0d_%h_post_flags", d, ins), flags[d], efl);
    check_eq($sformatf("d%0d_%h_retired", d, ins), retired[d], ret_exp(d));
  endtask

  initial begin
    int dones;
    load = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rst_n[d]       = 1'b0;
      instr_valid[d] = 1'b0;
      instr[d]       = 16'h0000;
      exp_ret[d]     = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_rst_ready", d), instr_ready[d], 1);
      check_eq($sformatf("d%0d_rst_flags", d), flags[d], 0);
      check_eq($sformatf("d%0d_rst_we", d), rf_we[d], 0);
      check_eq($sformatf("d%0d_rst_done", d), done[d], 0);
      check_eq($sformatf("d%0d_rst_ctrl", d), alu_ctrl[d], 0);
      check_eq($sformatf("d%0d_rst_retired", d), retired[d], 0);
    end
    load = 1'b0;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Instance 0, latency 1: ADD, then SUB giving N and borrow.
    run_instr(0, 16'h0312, 16'h00AA, 16'h0011, 1'b1, 16'h00BB, 4'b0000);
    run_instr(0, 16'h1921, 16'h0011, 16'h00AA, 1'b1, 16'hFF67, 4'b1010);

    // Back-to-back attempt with instr_valid held high: r8=r1-r2, then r8=r8+r3.
    dones = 0;
    instr[0]       = 16'h1812;
    instr_valid[0] = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (done[0]) dones++;
      case (cyc)
        1: begin
          check_eq("hs_c1_ra1", rf_raddr1[0], 1);
          instr[0] = 16'h0883;
        end
        3: begin
          check_eq("hs_c3_ready", instr_ready[0], 0);
          check_eq("hs_c3_wdata", rf_wdata[0], 16'h0099);
        end
        4: check_eq("hs_c4_ready", instr_ready[0], 1);
        5: begin
          check_eq("hs_c5_ra1", rf_raddr1[0], 8);
          check_eq("hs_c5_ra2", rf_raddr2[0], 3);
        end
        7: begin
          check_eq("hs_c7_we", rf_we[0], 1);
          check_eq("hs_c7_wdata", rf_wdata[0], 16'h0154);
        end
        8: instr_valid[0] = 1'b0;
        9: check_eq("hs_c9_ready", instr_ready[0], 1);
        default: ;
      endcase
    end
    check_eq("hs_done_count", dones, 2);
    exp_ret[0] += 2;
    check_eq("hs_retired", retired[0], ret_exp(0));

    run_instr(0, 16'hE056, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b0100);
    run_instr(0, 16'hF000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0100);

    // Instance 1, latency 3: CMP then NOP keeping flags.
    run_instr(1, 16'hE056, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b0100);
    run_instr(1, 16'hF000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0100);

    // Reset during the second EXEC cycle.
    instr[1]       = 16'h0312;
    instr_valid[1] = 1'b1;
    @(negedge clk);
    instr_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ex2_in1", alu_in1[1], 16'h00AA);
    #2 rst_n[1] = 1'b0;
    #1;
    exp_ret[1] = 0;
    check_eq("rst_mid_ready", instr_ready[1], 1);
    check_eq("rst_mid_flags", flags[1], 0);
    check_eq("rst_mid_in1", alu_in1[1], 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("rst_hold%0d_we", k), rf_we[1], 0);
      check_eq($sformatf("rst_hold%0d_done", k), done[1], 0);
    end
    rst_n[1] = 1'b1;
    @(negedge clk);
    check_eq("rst_rel_retired", retired[1], 0);
    run_instr(1, 16'h0312, 16'h00AA, 16'h0011, 1'b1, 16'h00BB, 4'b0000);

`ifdef SEQ_RETIRE_CNT_EN
    force g_dut[0].u_dut.retired_q = 16'hFFFF;
    #1 release g_dut[0].u_dut.retired_q;
    check_eq("wrap_preload", retired[0], 16'hFFFF);
    exp_ret[0] = 65535;
    run_instr(0, 16'hF000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0100);
    check_eq("wrap_zero", retired[0], 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle control FSM that sequences the 16-bit ALU datapath for the RISC core. Accepts one instruction per valid/ready handshake and reads two source registers from the register file. Drives the ALU operands and control code, latches the result and the NZCV flags, then writes the result back. Sits between the instruction source (fetch stage or testbench) and the ALU/register file pair.

Parameters:
- ALU_LATENCY, 1: number of EXEC cycles before the ALU output and flags are sampled; legal range 1..15.
- OP_CMP, 4'hE: opcode that updates flags only, with no register writeback.
- OP_NOP, 4'hF: opcode that bypasses the ALU; no flag update and no writeback.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept.
- instr  in  16  instruction: [15:12] op / ALU control, [11:8] rd, [7:4] rs1, [3:0] rs2.
- rf_raddr1  out  4  register file read address, port 1.
- rf_raddr2  out  4  register file read address, port 2.
- rf_rdata1  in  16  read data for port 1; combinational from address.
- rf_rdata2  in  16  read data for port 2; combinational from address.
- alu_in1  out  16  ALU operand 1.
- alu_in2  out  16  ALU operand 2.
- alu_ctrl  out  4  ALU control code.
- alu_out  in  16  ALU result.
- alu_n  in  1  ALU negative flag.
- alu_z  in  1  ALU zero flag.
- alu_c  in  1  ALU carry flag.
- alu_v  in  1  ALU overflow flag.
- rf_we  out  1  register file write enable.
- rf_waddr  out  4  write address.
- rf_wdata  out  16  write data.
- flags  out  4  architectural NZCV register, {N,Z,C,V}.
- done  out  1  one-cycle retire pulse.
- retired  out  16  retired-instruction count; see Optional Feature.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State → IDLE.
  - instr_ready=1.
  - All other outputs, the internal IR, operand registers, result register, flags and wait counter → 0.
  - Any in-flight instruction is discarded; no writeback occurs.
- States: IDLE, DECODE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready: latch instr into IR and go to DECODE.
  - instr_ready=0 in every other state, so back-to-back issue is impossible.
- DECODE (1 cycle):
  - rf_raddr1=IR[7:4], rf_raddr2=IR[3:0].
  - On exit, capture rf_rdata1/2 into opA/opB.
  - Next state: WB if op==OP_NOP, else EXEC with wait counter=ALU_LATENCY-1.
- EXEC:
  - alu_in1=opA, alu_in2=opB, alu_ctrl=IR[15:12], held stable for the whole state.
  - Counter decrements each cycle.
  - In the cycle the counter==0: capture alu_out into the result register and {alu_n,alu_z,alu_c,alu_v} into flags, then go to WB.
  - EXEC therefore lasts exactly ALU_LATENCY cycles.
- WB (1 cycle):
  - done=1.
  - rf_we=1 only if op∉{OP_CMP,OP_NOP}, with rf_waddr=IR[11:8] and rf_wdata=result.
  - Next state: IDLE.
- Outside their states, alu_in*/alu_ctrl/rf_raddr* hold 0, and rf_we/done are 0.
- Latency: handshake edge at cycle 0 gives DECODE at cycle 1, EXEC at cycles 2..1+L, WB at cycle 2+L, and instr_ready=1 again at cycle 3+L. NOP retires at cycle 2.
- Flags:
  - Update only on an EXEC capture.
  - Persist across NOP and across IDLE.
  - Visible on flags the cycle after capture, i.e. during WB.
- rd==rs1 or rd==rs2 is legal: operands are captured before writeback.
- instr_valid dropping while instr_ready=0 has no effect; instr is ignored outside IDLE.
- Reset asserted mid-EXEC or mid-WB: rf_we deasserts immediately (asynchronous) and the flags are cleared.

Optional Feature:
Macro SEQ_RETIRE_CNT_EN.
- Defined: `retired` is a 16-bit counter that increments by 1 on every done pulse, including NOP and CMP. It wraps from 16'hFFFF to 0 and resets to 0.
- Undefined: `retired` is tied to 16'h0000 and no counter logic exists.

Test Plan:
1. ADD, ALU_LATENCY=1: RF r1=16'h00AA, r2=16'h0011, ALU models ctrl 0=add; issue instr 16'h0312 → rf_raddr1=1, rf_raddr2=2 in DECODE; alu_in1=00AA, alu_in2=0011 for 1 cycle; WB at cycle 3 with rf_we=1, waddr=3, wdata=00BB, done=1; flags=4'b0000; instr_ready=1 at cycle 4.
2. CMP, ALU_LATENCY=3: operands 16'h0005/16'h0005 with ALU subtract giving Z=1; op=E → EXEC lasts exactly 3 cycles; WB has rf_we=0 and done=1; flags=4'b0100.
3. NOP after test 2: instr 16'hF000 → DECODE then WB at cycle 2; no alu_ctrl activity, rf_we=0, flags remain 4'b0100.
4. Handshake: hold instr_valid=1 continuously with two different instructions → second is accepted only on the edge after WB; exactly two done pulses.
5. Reset mid-operation: assert rst_n=0 during the 2nd EXEC cycle (L=3) → instr_ready=1, flags=0, no rf_we pulse; a new instruction after release completes normally.
6. SEQ_RETIRE_CNT_EN defined: 5 instructions (ADD, CMP, NOP, ADD, NOP) → retired=5. Preload the counter near wrap via 16'hFFFF+1 instructions, or force → reaches 0. Undefined: retired stays 0.
